m68k_bus_responder: RTL and testbench

Target-side counterpart to the 68000 bus-master wrapper. Watches the asynchronous-style 68000 bus (as_n, uds_n, lds_n, rw_n, fc), decodes each cycle and converts it into a single-request memory/peripheral handshake. Answers with dtack_n for normal space, with vpa_n for 6800-peripheral space and interrupt acknowledge (autovector), and with berr on timeout. Sits between the CPU wrapper and the address-decoded RAM/ROM/IO fabric.

---
 rtl/m68k_bus_pkg.sv | 15 +
 rtl/m68k_bus_responder.sv | 160 ++++++++++++++++
 tb/tb_m68k_bus_responder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/m68k_bus_pkg.sv
// m68k_bus_pkg: shared state encoding, function codes and defaults for the 68000 bus responder
package m68k_bus_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_WSTRB,
        S_REQ,
        S_ACK,
        S_VPA,
        S_BERR,
        S_DONE
    } state_t;
    localparam logic [2:0] FC_IACK      = 3'b111;
    localparam logic [3:0] VPA_PAGE_DEF = 4'hE;
    localparam int         TIMEOUT_DEF  = 255;
endpackage

// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: decodes 68000 bus cycles into a single-request backend handshake with dtack/vpa/berr replies
module m68k_bus_responder
    import m68k_bus_pkg::*;
#(
    parameter logic [3:0] VPA_PAGE = VPA_PAGE_DEF,
    parameter int         TIMEOUT  = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        as_n,
    input  logic        uds_n,
    input  logic        lds_n,
    input  logic        rw_n,
    input  logic [2:0]  fc,
    input  logic [22:0] addr,
    input  logic [15:0] cpu_wdata,
    output logic [15:0] cpu_rdata,
    output logic        dtack_n,
    output logic        vpa_n,
    output logic        berr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata
);
    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        periph_q, pend_q, req_q, we_q, dtack_n_q, vpa_n_q, berr_q;
    logic [1:0]  be_q;
    logic [22:0] addr_q;
    logic [15:0] wdata_q, rdata_q;
    logic        strobe, expired, tick;

    assign strobe  = !uds_n || !lds_n;
    assign expired = cnt_q == TO;
    // Peripheral cycles only time out while their request is still outstanding
    assign tick    = state_q == S_WSTRB || state_q == S_REQ ||
                     (state_q == S_VPA && periph_q && (pend_q || req_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            periph_q  <= 1'b0;
            pend_q    <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            dtack_n_q <= 1'b1;
            vpa_n_q   <= 1'b1;
            berr_q    <= 1'b0;
            be_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            if (tick && !expired) cnt_q <= cnt_q + 8'd1;
            case (state_q)
                S_IDLE: if (!as_n) begin
                    addr_q <= addr;
                    we_q   <= !rw_n;
                    be_q   <= ~{uds_n, lds_n};
                    cnt_q  <= '0;
                    if (fc == FC_IACK) begin
                        state_q  <= S_VPA;
                        vpa_n_q  <= 1'b0;
                        periph_q <= 1'b0;
                    end else if (addr[22:19] == VPA_PAGE) begin
                        // Peripheral writes hold the request back until the strobes arrive
                        state_q  <= S_VPA;
                        vpa_n_q  <= 1'b0;
                        periph_q <= 1'b1;
                        req_q    <= rw_n;
                        pend_q   <= !rw_n;
                    end else if (rw_n) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end else begin
                        state_q <= S_WSTRB;
                    end
                end
                S_WSTRB: if (as_n) begin
                    state_q <= S_DONE;
                end else if (strobe) begin
                    be_q    <= ~{uds_n, lds_n};
                    wdata_q <= cpu_wdata;
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end else if (expired) begin
                    berr_q  <= 1'b1;
                    state_q <= S_BERR;
                end
                S_REQ: if (as_n) begin
                    req_q   <= 1'b0;
                    state_q <= S_DONE;
                end else if (mem_ack) begin
                    rdata_q   <= mem_rdata;
                    req_q     <= 1'b0;
                    dtack_n_q <= 1'b0;
                    state_q   <= S_ACK;
                end else if (expired) begin
                    req_q   <= 1'b0;
                    berr_q  <= 1'b1;
                    state_q <= S_BERR;
                end
                S_ACK: if (as_n) begin
                    dtack_n_q <= 1'b1;
                    state_q   <= S_DONE;
                end
                S_VPA: if (as_n) begin
                    vpa_n_q <= 1'b1;
                    req_q   <= 1'b0;
                    pend_q  <= 1'b0;
                    state_q <= S_DONE;
                end else if (req_q && mem_ack) begin
                    rdata_q <= mem_rdata;
                    req_q   <= 1'b0;
                end else if (pend_q && strobe) begin
                    be_q    <= ~{uds_n, lds_n};
                    wdata_q <= cpu_wdata;
                    req_q   <= 1'b1;
                    pend_q  <= 1'b0;
                end else if (tick && expired) begin
                    req_q   <= 1'b0;
                    pend_q  <= 1'b0;
                    vpa_n_q <= 1'b1;
                    berr_q  <= 1'b1;
                    state_q <= S_BERR;
                end
                S_BERR: if (as_n) begin
                    berr_q  <= 1'b0;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    dtack_n_q <= 1'b1;
                    vpa_n_q   <= 1'b1;
                    berr_q    <= 1'b0;
                    req_q     <= 1'b0;
                    pend_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cpu_rdata = rdata_q;
    assign dtack_n   = dtack_n_q;
    assign vpa_n     = vpa_n_q;
    assign berr      = berr_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder: drives directed and random 68000 bus cycles and checks replies against a cycle-timeline model
module tb_m68k_bus_responder;
    logic        clk = 1'b0, reset = 1'b1;
    logic        as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, rw_n = 1'b1;
    logic [2:0]  fc = '0;
    logic [22:0] addr = '0;
    logic [15:0] cpu_wdata = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [15:0] cpu_rdata, mem_wdata;
    logic        dtack_n, vpa_n, berr, mem_req, mem_we;
    logic [1:0]  mem_be;
    logic [22:0] mem_addr;
    int          errors = 0, checks = 0;

    m68k_bus_responder dut (
        .clk(clk), .reset(reset), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw_n(rw_n),
        .fc(fc), .addr(addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .dtack_n(dtack_n), .vpa_n(vpa_n), .berr(berr), .mem_req(mem_req), .mem_we(mem_we),
        .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // kind: 0 normal, 1 peripheral page, 2 interrupt acknowledge.
    // Sample k is taken at the negedge following edge N+k, where N samples as_n low.
    // lat = req-high cycles before the backend acks (0 = never), s = edge offset of write strobes,
    // hold = extra cycles as_n stays low after the reply, abort_k = sample where the master gives up.
    task automatic xact(input int kind, input logic [22:0] a, input logic [2:0] f, input bit rd,
                        input logic [1:0] be, input logic [15:0] wd, input logic [15:0] rdv,
                        input int lat, input int s, input int hold, input int abort_k);
        int r0, fin, end_k;
        bit to, req_exp;
        r0    = (rd || kind == 2) ? 0 : s;
        to    = kind != 2 && (lat == 0 || r0 + lat > 256);
        fin   = to ? 256 : r0 + lat;
        end_k = abort_k != 0 ? abort_k : (kind == 2 ? 2 : fin) + hold;
        @(negedge clk);
        as_n = 1'b0; addr = a; fc = f; rw_n = rd; cpu_wdata = wd;
        {uds_n, lds_n} = rd ? ~be : 2'b11;
        for (int k = 0; k <= end_k + 1; k++) begin
            @(negedge clk);
            if (k <= end_k) begin
                req_exp = kind != 2 && k >= r0 && k < fin;
                check("mem_req", 32'(mem_req), 32'(req_exp));
                check("dtack_n", 32'(dtack_n), 32'(!(kind == 0 && !to && k >= fin)));
                check("vpa_n", 32'(vpa_n), 32'(!(kind != 0 && !(to && k >= 256))));
                check("berr", 32'(berr), 32'(to && k >= 256));
                if (req_exp) begin
                    check("mem_addr", 32'(mem_addr), 32'(a));
                    check("mem_we", 32'(mem_we), 32'(!rd));
                    check("mem_be", 32'(mem_be), 32'(be));
                    if (!rd) check("mem_wdata", 32'(mem_wdata), 32'(wd));
                end
                if (kind != 2 && !to && k >= fin) check("cpu_rdata", 32'(cpu_rdata), 32'(rdv));
            end else begin
                check("rel_req", 32'(mem_req), 32'(0));
                check("rel_dtack_n", 32'(dtack_n), 32'(1));
                check("rel_vpa_n", 32'(vpa_n), 32'(1));
                check("rel_berr", 32'(berr), 32'(0));
            end
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            if (!rd && k + 1 == s) {uds_n, lds_n} = ~be;
            if (kind != 2 && lat != 0 && k == r0 + lat - 1) begin
                mem_ack = 1'b1;
                mem_rdata = rdv;
            end
            if (k == end_k) begin
                as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [22:0] a;
        logic [2:0]  f;
        int          kind;
        bit          rd;
        repeat (2) @(negedge clk);
        check("rst_req", 32'(mem_req), 32'(0));
        check("rst_dtack_n", 32'(dtack_n), 32'(1));
        check("rst_vpa_n", 32'(vpa_n), 32'(1));
        check("rst_berr", 32'(berr), 32'(0));
        check("rst_be", 32'(mem_be), 32'(0));
        check("rst_rdata", 32'(cpu_rdata), 32'(0));
        reset = 1'b0;

        xact(0, 23'h000200, 3'b101, 1, 2'b11, 16'h0, 16'hA55A, 3, 0, 1, 0);
        xact(0, 23'h000080, 3'b001, 0, 2'b01, 16'h0042, 16'h0, 2, 2, 1, 0);
        xact(2, {20'hFFFFF, 3'd4}, 3'b111, 1, 2'b01, 16'h0, 16'h0, 0, 0, 1, 0);
        xact(1, 23'h77F0FF, 3'b101, 1, 2'b11, 16'h0, 16'h00FF, 4, 0, 2, 0);
        xact(1, 23'h700010, 3'b001, 0, 2'b10, 16'hBE00, 16'h0, 2, 3, 0, 0);
        xact(0, 23'h000010, 3'b101, 1, 2'b11, 16'h0, 16'h1234, 1, 0, 0, 0);
        xact(0, 23'h001000, 3'b101, 1, 2'b11, 16'h0, 16'h0, 0, 0, 1, 0);
        xact(0, 23'h001002, 3'b101, 1, 2'b11, 16'h0, 16'hC0DE, 256, 0, 0, 0);
        xact(0, 23'h001004, 3'b101, 1, 2'b11, 16'h0, 16'hDEAD, 257, 0, 1, 0);
        xact(0, 23'h002000, 3'b101, 1, 2'b11, 16'h0, 16'h0, 0, 0, 0, 5);
        xact(0, 23'h002002, 3'b001, 0, 2'b11, 16'h7777, 16'h0, 2, 100, 0, 3);

        // Reset while a read request is outstanding
        @(negedge clk);
        as_n = 1'b0; addr = 23'h003000; fc = 3'b101; rw_n = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_req", 32'(mem_req), 32'(1));
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_req", 32'(mem_req), 32'(0));
        check("mid_rst_dtack_n", 32'(dtack_n), 32'(1));
        check("mid_rst_vpa_n", 32'(vpa_n), 32'(1));
        check("mid_rst_berr", 32'(berr), 32'(0));
        check("mid_rst_we", 32'(mem_we), 32'(0));
        check("mid_rst_be", 32'(mem_be), 32'(0));
        reset = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        xact(0, 23'h003002, 3'b101, 1, 2'b11, 16'h0, 16'h5AA5, 2, 0, 1, 0);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3) == 3 ? int'($urandom_range(1, 2)) : 0;
            a = 23'($urandom);
            if (kind == 1) a[22:19] = 4'hE;
            else if (a[22:19] == 4'hE) a[22:19] = 4'h0;
            f = kind == 2 ? 3'b111 : 3'($urandom_range(1, 6));
            rd = kind == 2 ? 1'b1 : 1'($urandom);
            xact(kind, a, f, rd, 2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom),
                 $urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 2), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
